// File: rtl/uart_tx_drain.sv
// UART transmitter draining the comms byte FIFO onto the host TX line.
// Pops one byte per frame, 8 data bits LSB first, configurable stop bits.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    input  logic       fifo_data_valid,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam logic [31:0] TMAX      = 32'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [31:0] r_timer;
    logic [31:0] w_timer_n;
    logic [2:0]  r_index;
    logic [2:0]  w_index_n;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_n;
    logic        r_tx;
    logic        w_tx_n;
    logic        r_busy;
    logic        w_busy_n;
    logic        w_fetch;
    logic        w_bit_end;
    logic        w_last_stop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_index <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_timer <= w_timer_n;
            r_index <= w_index_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
            r_busy  <= w_busy_n;
        end
    end

    always_comb begin
        w_fetch     = !reset && (r_state == S_IDLE) && enable && !fifo_empty;
        w_bit_end   = (r_timer == TMAX);
        w_last_stop = (r_index == LAST_STOP);
        w_state_n   = r_state;
        w_timer_n   = w_bit_end ? 32'd0 : r_timer + 32'd1;
        w_index_n   = r_index;
        w_shift_n   = r_shift;
        w_tx_n      = r_tx;
        w_busy_n    = r_busy;
        unique case (r_state)
            S_IDLE: begin
                w_timer_n = '0;
                // A strobe without valid leaves the byte in the FIFO
                if (w_fetch && fifo_data_valid) begin
                    w_shift_n = fifo_data;
                    w_state_n = S_START;
                    w_tx_n    = 1'b0;
                    w_busy_n  = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_n = S_DATA;
                    w_tx_n    = r_shift[0];
                    w_index_n = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_index == 3'd7) begin
                        w_state_n = S_STOP;
                        w_tx_n    = 1'b1;
                        w_index_n = '0;
                    end else begin
                        w_shift_n = r_shift >> 1;
                        w_tx_n    = r_shift[1];
                        w_index_n = r_index + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (w_last_stop) begin
                        w_state_n = S_IDLE;
                        w_busy_n  = 1'b0;
                        w_index_n = '0;
                    end else begin
                        w_index_n = r_index + 3'd1;
                    end
                end
            end
        endcase
    end

    assign fifo_read = w_fetch;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign byte_done = !reset && (r_state == S_STOP) && w_bit_end && w_last_stop;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: two instances (1 and 2 stop bits)
// fed from small FIFO models, frames checked cycle by cycle.
module tb_uart_tx_drain;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       sel;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    logic [7:0] mem1 [0:15];
    logic [7:0] mem2 [0:15];
    int         wr1 = 0;
    int         wr2 = 0;
    int         rp1 = 0;
    int         rp2 = 0;

    logic       empty1, empty2, valid1, valid2, rd1, rd2;
    logic       tx1, tx2, busy1, busy2, bd1, bd2;
    logic [7:0] data1, data2;
    logic       m_rd, m_tx, m_busy, m_bd;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rd1) rp1 <= rp1 + 1;
        if (rd2) rp2 <= rp2 + 1;
    end

    assign empty1 = (rp1 == wr1);
    assign empty2 = (rp2 == wr2);
    assign data1  = mem1[rp1[3:0]];
    assign data2  = mem2[rp2[3:0]];
    assign valid1 = rd1 && !empty1;
    assign valid2 = rd2 && !empty2;

    assign m_rd   = sel ? rd2 : rd1;
    assign m_tx   = sel ? tx2 : tx1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_bd   = sel ? bd2 : bd1;

    uart_tx_drain #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u1 (
        .clock(clock), .reset(reset), .enable(enable),
        .fifo_empty(empty1), .fifo_data(data1),
        .fifo_data_valid(valid1), .fifo_read(rd1),
        .tx(tx1), .busy(busy1), .byte_done(bd1)
    );

    uart_tx_drain #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u2 (
        .clock(clock), .reset(reset), .enable(enable),
        .fifo_empty(empty2), .fifo_data(data2),
        .fifo_data_valid(valid2), .fifo_read(rd2),
        .tx(tx2), .busy(busy2), .byte_done(bd2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic s, input logic [7:0] b);
        if (s) begin
            mem2[wr2[3:0]] = b;
            wr2 = wr2 + 1;
        end else begin
            mem1[wr1[3:0]] = b;
            wr1 = wr1 + 1;
        end
    endtask

    // Returns at the negedge of the fetch cycle (or after the budget)
    task automatic wait_fetch(input string tag, output int fcyc);
        int n;
        n = 0;
        @(negedge clock);
        while (!m_rd && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_fetch"}, int'(m_rd), 1);
        fcyc = cyc;
    endtask

    task automatic frame(input string tag, input logic [7:0] b,
                         input int nstop, input int drop_k,
                         output int fcyc);
        int  tbad, bbad, rdn, bdn, bdk, p, len;
        logic e;
        tbad = 0; bbad = 0; rdn = 0; bdn = 0; bdk = -1;
        len = (9 + nstop) * 4;
        wait_fetch(tag, fcyc);
        chk({tag, "_idle_tx"}, int'(m_tx), 1);
        chk({tag, "_idle_busy"}, int'(m_busy), 0);
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            if (k == drop_k) enable = 1'b0;
            p = k / 4;
            if (p == 0)      e = 1'b0;
            else if (p <= 8) e = b[p-1];
            else             e = 1'b1;
            if (m_tx !== e) tbad++;
            if (m_busy !== 1'b1) bbad++;
            if (m_rd) rdn++;
            if (m_bd) begin
                bdn++;
                bdk = k;
            end
        end
        chk({tag, "_tx_bits"}, tbad, 0);
        chk({tag, "_busy"}, bbad, 0);
        chk({tag, "_no_read"}, rdn, 0);
        chk({tag, "_done_cnt"}, bdn, 1);
        chk({tag, "_done_pos"}, bdk, len - 1);
    endtask

    initial begin
        int f0, f1, f2, fe, nrd, nbad;
        reset  = 1'b1;
        enable = 1'b1;
        sel    = 1'b0;
        push(1'b0, 8'hA5);
        repeat (3) @(negedge clock);
        chk("rst_read", int'(m_rd), 0);
        chk("rst_tx", int'(m_tx), 1);
        chk("rst_busy", int'(m_busy), 0);
        chk("rst_done", int'(m_bd), 0);

        @(posedge clock); #1 reset = 1'b0;
        frame("a5", 8'hA5, 1, -1, f0);
        @(negedge clock);
        chk("a5_empty", int'(empty1), 1);
        chk("a5_after_busy", int'(m_busy), 0);

        nrd = 0; nbad = 0;
        repeat (200) begin
            @(negedge clock);
            if (m_rd) nrd++;
            if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_bd !== 1'b0) nbad++;
        end
        chk("empty_read", nrd, 0);
        chk("empty_lines", nbad, 0);

        @(posedge clock); #1;
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        push(1'b0, 8'h3C);
        frame("b00", 8'h00, 1, -1, f0);
        frame("bff", 8'hFF, 1, -1, f1);
        chk("b2b_period1", f1 - f0, 41);
        frame("b3c", 8'h3C, 1, -1, f2);
        chk("b2b_period2", f2 - f1, 41);

        @(posedge clock); #1;
        push(1'b0, 8'h5A);
        push(1'b0, 8'h11);
        frame("en5a", 8'h5A, 1, 13, f0);
        nrd = 0; nbad = 0;
        repeat (10) begin
            @(negedge clock);
            if (m_rd) nrd++;
            if (m_busy !== 1'b0 || m_tx !== 1'b1) nbad++;
        end
        chk("en_off_read", nrd, 0);
        chk("en_off_idle", nbad, 0);
        @(posedge clock); #1 enable = 1'b1;
        fe = cyc;
        frame("en11", 8'h11, 1, -1, f1);
        chk("en_fetch_cyc", f1, fe);

        @(posedge clock); #1;
        push(1'b0, 8'h96);
        push(1'b0, 8'h42);
        wait_fetch("rst96", f0);
        repeat (18) @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("midrst_read", int'(m_rd), 0);
        chk("midrst_done", int'(m_bd), 0);
        chk("midrst_busy_pre", int'(m_busy), 1);
        @(posedge clock); #1 reset = 1'b0;
        chk("midrst_tx", int'(m_tx), 1);
        chk("midrst_busy", int'(m_busy), 0);
        frame("r42", 8'h42, 1, -1, f1);

        sel = 1'b1;
        @(posedge clock); #1 push(1'b1, 8'h81);
        frame("s2", 8'h81, 2, -1, f0);
        @(negedge clock);
        chk("s2_empty", int'(empty2), 1);
        chk("s2_after_busy", int'(m_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
